// File: rtl/copy_job_scheduler.sv
// Round-robin scheduler that hands copy jobs to a single copier engine
// and reports completion, checksum and timeout status per job.
module copy_job_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1048575
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [31*NREQ-1:0]   req_src,
    input  logic [31*NREQ-1:0]   req_dst,
    input  logic [31*NREQ-1:0]   req_len,
    output logic [31:0]          wq,
    output logic                 loadS,
    output logic                 loadD,
    output logic                 loadL,
    input  logic [16:0]          chkBusy,
    output logic                 done_valid,
    output logic [1:0]           done_id,
    output logic [15:0]          done_sum,
    output logic                 done_err,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE, LD_S, LD_D, LD_L, SETTLE, WAIT, DONE
    } state_t;

    localparam logic [19:0] TMO = 20'(TIMEOUT);

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic        lock_q, lock_d;
    logic [1:0]  last_q;
    logic [30:0] src_q, dst_q, len_q;
    logic [1:0]  id_q;
    logic [1:0]  did_q, did_d;
    logic [15:0] sum_q, sum_d;
    logic        err_q, err_d;

    logic        found;
    logic [1:0]  gnt_id;
    logic [1:0]  rr_idx;
    logic        xfer;
    logic [30:0] g_src, g_dst, g_len;

    // Search starts one past the last granted requester.
    always_comb begin
        found  = 1'b0;
        gnt_id = last_q;
        rr_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_idx = last_q + 2'(k);
            if (!found && req_valid[rr_idx]) begin
                found  = 1'b1;
                gnt_id = rr_idx;
            end
        end
    end

    assign xfer  = (state_q == IDLE) && !lock_q && !reset && found;
    assign g_src = req_src[31*gnt_id +: 31];
    assign g_dst = req_dst[31*gnt_id +: 31];
    assign g_len = req_len[31*gnt_id +: 31];

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready = {{(NREQ-1){1'b0}}, 1'b1} << gnt_id;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lock_d  = lock_q & chkBusy[0];
        did_d   = did_q;
        sum_d   = sum_q;
        err_d   = err_q;
        wq      = '0;
        loadS   = 1'b0;
        loadD   = 1'b0;
        loadL   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (g_len == '0) begin
                        state_d = DONE;
                        did_d   = gnt_id;
                        sum_d   = '0;
                        err_d   = 1'b0;
                    end else begin
                        state_d = LD_S;
                    end
                end
            end
            LD_S: begin
                wq      = {1'b0, src_q};
                loadS   = 1'b1;
                state_d = LD_D;
            end
            LD_D: begin
                wq      = {1'b0, dst_q};
                loadD   = 1'b1;
                state_d = LD_L;
            end
            LD_L: begin
                wq      = {1'b0, len_q};
                loadL   = 1'b1;
                cnt_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == 20'd1) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            WAIT: begin
                if (!chkBusy[0]) begin
                    state_d = DONE;
                    did_d   = id_q;
                    sum_d   = ~chkBusy[16:1];
                    err_d   = 1'b0;
                end else if (cnt_q == TMO) begin
                    // Copier still busy: refuse work until it drains.
                    state_d = DONE;
                    did_d   = id_q;
                    sum_d   = '0;
                    err_d   = 1'b1;
                    lock_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lock_q  <= 1'b0;
            last_q  <= 2'd3;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            id_q    <= '0;
            did_q   <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
            did_q   <= did_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
            if (xfer) begin
                last_q <= gnt_id;
                src_q  <= g_src;
                dst_q  <= g_dst;
                len_q  <= g_len;
                id_q   <= gnt_id;
            end
        end
    end

    assign done_valid = (state_q == DONE);
    assign done_id    = did_q;
    assign done_sum   = sum_q;
    assign done_err   = err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_copy_job_scheduler.sv
// Scoreboard bench for copy_job_scheduler with a behavioural copier
// whose checksum is derived from the loaded source address.
module tb_copy_job_scheduler;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] sum;
        logic        err;
    } done_t;

    typedef struct packed {
        logic [2:0]  st;
        logic [31:0] wq;
        int          cyc;
    } ld_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [123:0] req_src = '0;
    logic [123:0] req_dst = '0;
    logic [123:0] req_len = '0;
    logic [31:0]  wq;
    logic         loadS, loadD, loadL;
    logic [16:0]  chkBusy = '0;
    logic         done_valid;
    logic [1:0]   done_id;
    logic [15:0]  done_sum;
    logic         done_err;
    logic         busy;

    copy_job_scheduler #(.NREQ(4), .TIMEOUT(100)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst), .req_len(req_len),
        .wq(wq), .loadS(loadS), .loadD(loadD), .loadL(loadL),
        .chkBusy(chkBusy),
        .done_valid(done_valid), .done_id(done_id),
        .done_sum(done_sum), .done_err(done_err), .busy(busy)
    );

    always #5 clock = ~clock;

    // Copier model: busy cp_busy cycles after loadL, sum = src + cp_off.
    logic        cp_stuck = 1'b0;
    int          cp_busy  = 20;
    logic [15:0] cp_off   = '0;
    logic [30:0] cp_src   = '0;
    int          cp_rem   = 0;
    logic        cp_on    = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            cp_on  = 1'b0;
            cp_rem = 0;
        end else begin
            if (loadS) cp_src = wq[30:0];
            if (loadL) begin
                cp_on  = 1'b1;
                cp_rem = cp_busy;
            end else if (cp_on && !cp_stuck) begin
                if (cp_rem > 0) cp_rem--;
                if (cp_rem == 0) cp_on = 1'b0;
            end
        end
        chkBusy = {~(cp_src[15:0] + cp_off), cp_on};
    end

    int    checks = 0;
    int    passed = 0;
    int    cyc = 0;
    int    xfer_cyc = 0;
    int    done_cyc = 0;
    logic  drop_on_grant = 1'b1;
    done_t sb[$];
    done_t obs[$];
    ld_t   lds[$];
    int    grants[$];

    task automatic step();
        logic x;
        int   g;
        x = 1'b0;
        g = 0;
        @(negedge clock);
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (req_ready[i] && req_valid[i]) begin
                x = 1'b1;
                g = i;
            end
        end
        if (x) begin
            grants.push_back(g);
            xfer_cyc = cyc;
        end
        if (loadS || loadD || loadL)
            lds.push_back(ld_t'{{loadS, loadD, loadL}, wq, cyc});
        if (done_valid) begin
            obs.push_back(done_t'{done_id, done_sum, done_err});
            done_cyc = cyc;
        end
        @(posedge clock);
        #1;
        if (x && drop_on_grant) req_valid[g] = 1'b0;
    endtask

    task automatic set_job(input int i, input logic [30:0] s,
                           input logic [30:0] d, input logic [30:0] l);
        req_src[31*i +: 31] = s;
        req_dst[31*i +: 31] = d;
        req_len[31*i +: 31] = l;
        req_valid[i] = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        sb.delete();
        obs.delete();
        lds.delete();
        grants.delete();
    endtask

    task automatic test_reset();
        req_valid = '0;
        do_reset();
        @(negedge clock);
        checks++;
        if ({req_ready, loadS, loadD, loadL, done_valid, busy, done_err} !== 9'd0)
            $display("FAIL reset_ctrl: got %b expected 0",
                     {req_ready, loadS, loadD, loadL, done_valid, busy, done_err});
        else passed++;
        checks++;
        if (wq !== 32'd0) $display("FAIL reset_wq: got %h expected 0", wq);
        else passed++;
        checks++;
        if ({done_id, done_sum} !== 18'd0)
            $display("FAIL reset_done: got %h expected 0", {done_id, done_sum});
        else passed++;
        @(posedge clock);
        #1;
    endtask

    task automatic test_single();
        done_t e, o;
        cp_busy = 20;
        cp_off  = 16'h1134;
        drop_on_grant = 1'b1;
        lds.delete();
        set_job(1, 31'h100, 31'h200, 31'd16);
        sb.push_back(done_t'{2'd1, 16'h1234, 1'b0});
        for (int k = 0; k < 100 && obs.size() < 1; k++) step();
        repeat (5) step();
        checks++;
        if (obs.size() != 1) $display("FAIL single_count: got %0d pulses expected 1", obs.size());
        else passed++;
        if (obs.size() > 0) begin
            o = obs.pop_front();
            e = sb.pop_front();
            checks++;
            if (o !== e) $display("FAIL single_done: got %h expected %h", o, e);
            else passed++;
        end
        checks++;
        if (lds.size() != 3) $display("FAIL single_loads: got %0d strobes expected 3", lds.size());
        else passed++;
        if (lds.size() == 3) begin
            checks++;
            if (lds[0] !== ld_t'{3'b100, 32'h100, xfer_cyc + 1})
                $display("FAIL single_ldS: got %h expected %h", lds[0], ld_t'{3'b100, 32'h100, xfer_cyc + 1});
            else passed++;
            checks++;
            if (lds[1] !== ld_t'{3'b010, 32'h200, xfer_cyc + 2})
                $display("FAIL single_ldD: got %h expected %h", lds[1], ld_t'{3'b010, 32'h200, xfer_cyc + 2});
            else passed++;
            checks++;
            if (lds[2] !== ld_t'{3'b001, 32'd16, xfer_cyc + 3})
                $display("FAIL single_ldL: got %h expected %h", lds[2], ld_t'{3'b001, 32'd16, xfer_cyc + 3});
            else passed++;
        end
        checks++;
        if ({done_id, done_sum, done_err, done_valid} !== {2'd1, 16'h1234, 1'b0, 1'b0})
            $display("FAIL single_hold: got %h expected %h",
                     {done_id, done_sum, done_err, done_valid}, {2'd1, 16'h1234, 1'b0, 1'b0});
        else passed++;
    endtask

    task automatic test_zero_len();
        done_t e, o;
        lds.delete();
        set_job(2, 31'h300, 31'h400, 31'd0);
        sb.push_back(done_t'{2'd2, 16'h0000, 1'b0});
        for (int k = 0; k < 50 && obs.size() < 1; k++) step();
        checks++;
        if (obs.size() != 1) $display("FAIL zero_count: got %0d pulses expected 1", obs.size());
        else passed++;
        if (obs.size() > 0) begin
            o = obs.pop_front();
            e = sb.pop_front();
            checks++;
            if (o !== e) $display("FAIL zero_done: got %h expected %h", o, e);
            else passed++;
        end
        checks++;
        if (lds.size() != 0) $display("FAIL zero_loads: got %0d strobes expected 0", lds.size());
        else passed++;
        checks++;
        if (done_cyc - xfer_cyc != 1)
            $display("FAIL zero_latency: got %0d cycles expected 1", done_cyc - xfer_cyc);
        else passed++;
    endtask

    task automatic test_round_robin();
        int    order [5] = '{0, 1, 2, 3, 0};
        done_t e, o;
        do_reset();
        cp_busy = 3;
        cp_off  = '0;
        drop_on_grant = 1'b0;
        for (int i = 0; i < 4; i++)
            set_job(i, 31'(32'h40 * i + 32'h10), 31'(32'h800 + i), 31'd1);
        for (int k = 0; k < 5; k++)
            sb.push_back(done_t'{2'(order[k]), 16'(32'h40 * order[k] + 32'h10), 1'b0});
        for (int k = 0; k < 400 && grants.size() < 5; k++) step();
        req_valid = '0;
        for (int k = 0; k < 200 && obs.size() < 5; k++) step();
        drop_on_grant = 1'b1;
        checks++;
        if (grants.size() != 5) $display("FAIL rr_count: got %0d grants expected 5", grants.size());
        else passed++;
        for (int k = 0; k < 5 && k < grants.size(); k++) begin
            checks++;
            if (grants[k] != order[k])
                $display("FAIL rr_grant%0d: got %0d expected %0d", k, grants[k], order[k]);
            else passed++;
        end
        while (obs.size() > 0 && sb.size() > 0) begin
            o = obs.pop_front();
            e = sb.pop_front();
            checks++;
            if (o !== e) $display("FAIL rr_done: got %h expected %h", o, e);
            else passed++;
        end
        checks++;
        if (sb.size() != 0) $display("FAIL rr_pending: got %0d unfinished expected 0", sb.size());
        else passed++;
        sb.delete();
    endtask

    task automatic test_timeout();
        done_t e, o;
        int    lcyc;
        cp_stuck = 1'b1;
        cp_busy  = 5;
        cp_off   = '0;
        lds.delete();
        obs.delete();
        set_job(3, 31'h77, 31'h88, 31'd5);
        sb.push_back(done_t'{2'd3, 16'h0000, 1'b1});
        for (int k = 0; k < 300 && obs.size() < 1; k++) step();
        lcyc = (lds.size() == 3) ? lds[2].cyc : -1000;
        checks++;
        if (obs.size() != 1) $display("FAIL tmo_count: got %0d pulses expected 1", obs.size());
        else passed++;
        if (obs.size() > 0) begin
            o = obs.pop_front();
            e = sb.pop_front();
            checks++;
            if (o !== e) $display("FAIL tmo_done: got %h expected %h", o, e);
            else passed++;
        end
        checks++;
        if (done_cyc - lcyc != 104)
            $display("FAIL tmo_latency: got %0d cycles expected 104", done_cyc - lcyc);
        else passed++;
        grants.delete();
        set_job(0, 31'h10, 31'h20, 31'd2);
        sb.push_back(done_t'{2'd0, 16'h0010, 1'b0});
        repeat (20) step();
        checks++;
        if (grants.size() != 0) $display("FAIL tmo_lockout: got %0d grants expected 0", grants.size());
        else passed++;
        cp_stuck = 1'b0;
        for (int k = 0; k < 50 && grants.size() < 1; k++) step();
        checks++;
        if (grants.size() != 1 || grants[0] != 0)
            $display("FAIL tmo_release: got %0d grants expected 1 to requester 0", grants.size());
        else passed++;
        for (int k = 0; k < 100 && obs.size() < 1; k++) step();
        if (obs.size() > 0) begin
            o = obs.pop_front();
            e = sb.pop_front();
            checks++;
            if (o !== e) $display("FAIL tmo_next: got %h expected %h", o, e);
            else passed++;
        end else begin
            checks++;
            $display("FAIL tmo_next: got no done pulse expected one");
        end
        sb.delete();
    endtask

    task automatic test_reset_mid_wait();
        done_t e, o;
        cp_busy = 50;
        lds.delete();
        obs.delete();
        set_job(0, 31'h123, 31'h456, 31'd8);
        for (int k = 0; k < 50 && lds.size() < 3; k++) step();
        repeat (5) step();
        checks++;
        if (busy !== 1'b1) $display("FAIL rst_busy: got %b expected 1", busy);
        else passed++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({req_ready, loadS, loadD, loadL, done_valid, busy, done_err} !== 9'd0)
            $display("FAIL rst_ctrl: got %b expected 0",
                     {req_ready, loadS, loadD, loadL, done_valid, busy, done_err});
        else passed++;
        checks++;
        if ({wq, done_id, done_sum} !== 50'd0)
            $display("FAIL rst_data: got %h expected 0", {wq, done_id, done_sum});
        else passed++;
        @(posedge clock);
        #1;
        repeat (60) step();
        checks++;
        if (obs.size() != 0) $display("FAIL rst_nopulse: got %0d pulses expected 0", obs.size());
        else passed++;
        cp_busy = 4;
        grants.delete();
        set_job(1, 31'h55, 31'h66, 31'd3);
        sb.push_back(done_t'{2'd1, 16'h0055, 1'b0});
        for (int k = 0; k < 100 && obs.size() < 1; k++) step();
        if (obs.size() > 0) begin
            o = obs.pop_front();
            e = sb.pop_front();
            checks++;
            if (o !== e) $display("FAIL rst_newjob: got %h expected %h", o, e);
            else passed++;
        end else begin
            checks++;
            $display("FAIL rst_newjob: got no done pulse expected one");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_len();
        test_round_robin();
        test_timeout();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
